// File: rtl/load_seq_pkg.sv
// Shared types and default timing for the flash load sequencer.
package load_seq_pkg;

   localparam int          CFG_W               = 5;
   localparam int          DEBOUNCE_CYCLES_DEF = 255;
   localparam int          HOLD_CYCLES_DEF     = 1000;
   localparam logic [23:0] TIMEOUT_CYCLES_DEF  = 24'hFFFFFF;

   typedef enum logic [2:0] {
      ST_DEBOUNCE,
      ST_START,
      ST_LOAD,
      ST_HOLD,
      ST_RUN,
      ST_ERROR
   } state_t;

endpackage

// File: rtl/config_debounce.sv
// Two-flop synchroniser followed by a stability counter for the config switches.
// cur    : latest synchronised value (changes immediately, not debounced)
// stable : cur has been unchanged for DEBOUNCE_CYCLES consecutive cycles
// dout   : last value that was seen stable
module config_debounce
   import load_seq_pkg::*;
#(
   parameter int WIDTH           = CFG_W,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] cur,
   output logic             stable,
   output logic [WIDTH-1:0] dout
);

   localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 2);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [WIDTH-1:0] s1, s2;
   logic [CW-1:0]    cnt;

   // synchronise the asynchronous switch inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= din;
         s2 <= s1;
      end
   end

   // track the candidate value; a change restarts the count, which saturates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur <= '0;
         cnt <= '0;
      end else if (s2 != cur) begin
         cur <= s2;
         cnt <= CNT_ONE;
      end else if (cnt < CNT_MAX) begin
         cnt <= cnt + CNT_ONE;
      end
   end

   assign stable = (cnt >= CNT_MAX);

   // capture the accepted value so the sequencer can latch it a cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      dout <= '0;
      else if (stable) dout <= cur;
   end

endmodule

// File: rtl/flash_load_sequencer.sv
// Sequences a flash config load: debounce the switches, run the flash reader
// with the RAM port muxed to it, hold the CPU in reset for a while, then run.
// All outputs are registered from the next state so they line up with it.
module flash_load_sequencer
   import load_seq_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int          HOLD_CYCLES     = HOLD_CYCLES_DEF,
   parameter logic [23:0] TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CFG_W-1:0] config_sel,
   input  logic             reload_req,
   input  logic             loader_complete,
   output logic             loader_run,
   output logic [CFG_W-1:0] loader_config,
   output logic             bus_to_loader,
   output logic             cpu_reset_n,
   output logic             busy,
   output logic             load_error,
   output logic [CFG_W-1:0] active_config
);

   localparam int             HCW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HCW-1:0] H_LAST  = (HOLD_CYCLES > 0) ? HCW'(HOLD_CYCLES - 1) : '0;
   localparam logic [23:0]    TO_LAST = (TIMEOUT_CYCLES != 24'd0) ? TIMEOUT_CYCLES - 24'd1 : 24'd0;

   state_t           state, state_nxt;
   logic [23:0]      tcnt;
   logic [HCW-1:0]   hcnt;
   logic [CFG_W-1:0] deb_cur, deb_cfg;
   logic             deb_stable;
   logic             ld_done;

   config_debounce #(
      .WIDTH           (CFG_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (config_sel),
      .cur    (deb_cur),
      .stable (deb_stable),
      .dout   (deb_cfg)
   );

   // a completion level already high on LOAD entry is ignored (tcnt == 0)
   assign ld_done = (state == ST_LOAD) && (tcnt != 24'd0) && loader_complete;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_DEBOUNCE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_DEBOUNCE: if (deb_stable) state_nxt = ST_START;
         ST_START:    state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (ld_done)              state_nxt = ST_HOLD;
            else if (tcnt >= TO_LAST) state_nxt = ST_ERROR;
         end
         ST_HOLD:     if (hcnt >= H_LAST) state_nxt = ST_RUN;
         ST_RUN: begin
            if (reload_req || (deb_stable && (deb_cur != active_config)))
               state_nxt = ST_START;
         end
         ST_ERROR: begin
            if (reload_req)                    state_nxt = ST_START;
            else if (deb_cur != loader_config) state_nxt = ST_DEBOUNCE;
         end
         default:     state_nxt = ST_DEBOUNCE;
      endcase
   end

   // LOAD timeout counter, cleared outside LOAD, saturating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 tcnt <= '0;
      else if (state != ST_LOAD)  tcnt <= '0;
      else if (tcnt != 24'hFFFFFF) tcnt <= tcnt + 24'd1;
   end

   // HOLD length counter, cleared outside HOLD, saturating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                hcnt <= '0;
      else if (state != ST_HOLD) hcnt <= '0;
      else if (hcnt < H_LAST)    hcnt <= hcnt + HCW'(1);
   end

   // config bookkeeping: latch the bank in START, commit it on completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loader_config <= '0;
         active_config <= '0;
      end else begin
         if (state == ST_START) loader_config <= deb_cfg;
         if (ld_done)           active_config <= loader_config;
      end
   end

   // registered control outputs decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loader_run    <= 1'b0;
         bus_to_loader <= 1'b0;
         cpu_reset_n   <= 1'b0;
         busy          <= 1'b1;
         load_error    <= 1'b0;
      end else begin
         loader_run    <= (state_nxt == ST_LOAD);
         bus_to_loader <= (state_nxt == ST_LOAD);
         cpu_reset_n   <= (state_nxt == ST_RUN);
         busy          <= !((state_nxt == ST_RUN) || (state_nxt == ST_ERROR));
         load_error    <= (state_nxt == ST_ERROR);
      end
   end

endmodule
